// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - NoC packet field layout and local-port output FSM encodings
package noc_pkg;

  // Packet field widths
  localparam int DIM   = 4;
  localparam int PID_W = 10;
  localparam int MID_W = 6;

  // Packet field LSB offsets within the 32-bit packet
  localparam int XDST_LSB = 28;
  localparam int YDST_LSB = 24;
  localparam int XSRC_LSB = 20;
  localparam int YSRC_LSB = 16;
  localparam int PID_LSB  = 6;
  localparam int MID_LSB  = 0;

  // Output (routing-stage side) handshake states
  typedef enum logic {
    O_IDLE = 1'b0,
    O_REQ  = 1'b1
  } ostate_t;

  // Destination coordinate {xDst, yDst} of a packet
  function automatic logic [2*DIM-1:0] pkt_dst(input logic [31:0] pkt);
    return {pkt[XDST_LSB +: DIM], pkt[YDST_LSB +: DIM]};
  endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// rtl/noc_fifo_mem.sv - FIFO storage array, one write port and one async read port
module noc_fifo_mem
  import noc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int dataWidth  = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [dataWidth-1:0]  wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [dataWidth-1:0]  rdata_o
);

  logic [dataWidth-1:0] mem_q [DEPTH];

  // Storage write; contents are not reset since pointers/count gate all reads
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/local_port_input_buffer.sv
// rtl/local_port_input_buffer.sv - router local-port input FIFO with Req/Gnt on both sides; LOCAL_PORT_STATS_EN adds traffic counters
module local_port_input_buffer
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID   = 6'b000_000,
  parameter int         dataWidth  = 32,
  parameter int         DEPTH      = 4,
  parameter int         ADDR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  output logic [dataWidth-1:0] PacketOut
`ifdef LOCAL_PORT_STATS_EN
  ,
  output logic [15:0]          PktInCount,
  output logic [15:0]          PktOutCount,
  output logic [ADDR_WIDTH:0]  MaxOccupancy
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  ostate_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  gnt_q, gnt_d;
  logic                  req_q, req_d;
  logic                  full_q, full_d;
  logic [dataWidth-1:0]  pkt_q, pkt_d;
  logic [dataWidth-1:0]  mem_rdata;
  logic                  accept;
  logic                  pop;

  // routerID only tags the optional statistics; kept visible to avoid a dangling parameter
  logic [5:0] unused_router_id;
  assign unused_router_id = routerID;

  // A grant in flight blocks a second accept because the injector drops Req one cycle late
  assign accept = ReqUpStr && !gnt_q && (count_q < DEPTH_C);
  assign pop    = (state_q == O_REQ) && GntDnStr;

  noc_fifo_mem #(
    .DEPTH      (DEPTH),
    .dataWidth  (dataWidth),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wptr_q),
    .wdata_i (PacketIn),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  // Write side and occupancy: grant pulse, write pointer, count and registered Full
  always_comb begin
    gnt_d  = accept;
    wptr_d = accept ? (wptr_q + PTR_ONE) : wptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  // Read side FSM: load the head into the output register, then hold it until granted
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pkt_d   = pkt_q;
    rptr_d  = rptr_q;
    case (state_q)
      O_IDLE: begin
        if (count_q != '0) begin
          pkt_d   = mem_rdata;
          req_d   = 1'b1;
          state_d = O_REQ;
        end
      end
      O_REQ: begin
        if (GntDnStr) begin
          req_d   = 1'b0;
          rptr_d  = rptr_q + PTR_ONE;
          state_d = O_IDLE;
        end
      end
    endcase
  end

  // State registers; reset discards any buffered or in-flight packet
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= O_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      gnt_q   <= 1'b0;
      req_q   <= 1'b0;
      full_q  <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      full_q  <= full_d;
      pkt_q   <= pkt_d;
    end
  end

  assign GntUpStr  = gnt_q;
  assign UpStrFull = full_q;
  assign ReqDnStr  = req_q;
  assign PacketOut = pkt_q;

`ifdef LOCAL_PORT_STATS_EN
  logic [15:0]         in_cnt_q, out_cnt_q;
  logic [ADDR_WIDTH:0] max_occ_q;

  // Traffic counters (wrap at 16 bits) and occupancy high-water mark
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      max_occ_q <= '0;
    end else begin
      if (accept) begin
        in_cnt_q <= in_cnt_q + 16'd1;
      end
      if (pop) begin
        out_cnt_q <= out_cnt_q + 16'd1;
      end
      if (count_d > max_occ_q) begin
        max_occ_q <= count_d;
      end
    end
  end

  assign PktInCount   = in_cnt_q;
  assign PktOutCount  = out_cnt_q;
  assign MaxOccupancy = max_occ_q;
`endif

endmodule
